heartbeat_kicker: RTL and testbench
===================================

// Module: heartbeat_kicker
// PURPOSE
//  Liveness source that drives the heartbeat input of watchdog_timer.
//  Emits periodic one-cycle heartbeat pulses only while the host keeps pinging and the DSP path is healthy.
//  Stops kicking on host starvation or after the watchdog has fired, so the watchdog trips and mutes the AM output.
//  Sits between the host register interface and watchdog_timer.
// PARAMETERS
//  KICK_PERIOD   1_250_000    cycles between heartbeat pulses (10 ms @125 MHz); must be >= 2
//  HOST_TIMEOUT  125_000_000  cycles without host_ping before entering STARVED (1 s)
//  CNT_W         32           width of period and host timers
// PORTS
//  clk           in   1   system clock
//  rstn          in   1   reset, synchronous, active-low
//  enable        in   1   block enable; same source as watchdog_timer.enable
//  host_ping     in   1   single-cycle pulse per host keepalive register write
//  dsp_ok        in   1   level: DSP datapath healthy
//  wd_triggered  in   1   level/pulse from watchdog_timer: watchdog has fired
//  heartbeat     out  1   one-cycle kick to watchdog_timer.heartbeat
//  alive         out  1   high in RUN
//  fault         out  1   high in FAULT
//  state_o       out  3   current state encoding (hb_state_t)
//  kick_count    out  16  heartbeats issued, saturating (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE; heartbeat, alive, fault=0; both timers and kick_count=0.
//  - States: IDLE, ARMED, RUN, STARVED, FAULT. Priority: rstn > enable=0 > wd_triggered > host_ping > timeout.
//  - Any state, enable=0 -> IDLE next cycle; timers cleared; fault cleared. This is the only FAULT exit.
//  - IDLE -> ARMED when enable=1.
//  - ARMED -> RUN on host_ping with dsp_ok=1. A ping with dsp_ok=0 is ignored.
//  - Any non-IDLE state, wd_triggered=1 -> FAULT; heartbeat forced 0 in the same edge; pings ignored.
//  - RUN, period timer:
//    - counts 0..KICK_PERIOD-1 and wraps; starts at 0 on RUN entry.
//    - heartbeat=1 for exactly the cycle after the timer equals KICK_PERIOD-1, if dsp_ok=1 in the terminal cycle.
//    - dsp_ok=0 at terminal: kick skipped; timer still wraps.
//  - RUN, host timer: increments each cycle; cleared by host_ping.
//    - Reaches HOST_TIMEOUT-1 -> STARVED.
//    - host_ping in the same cycle as timeout wins: stay RUN, timer cleared.
//  - STARVED: no kicks. host_ping with dsp_ok=1 -> RUN; period timer restarts at 0, so the next kick comes KICK_PERIOD cycles later.
//  - heartbeat is registered and never high on two consecutive cycles. It is never high outside RUN.
//  - Timer arithmetic is unsigned CNT_W. Compares are against parameter-1; no overflow is reachable.
//  - Reset or enable drop mid-period abandons the period; no partial or late kick is emitted.
// CONFIGURATION
//  HB_KICK_CNT_EN defined:
//    - kick_count increments on each heartbeat pulse and saturates at 16'hFFFF.
//    - Cleared by reset only; enable=0 does not clear it.
//  HB_KICK_CNT_EN undefined:
//    - Port kept; kick_count is tied to 16'h0000; no counter logic.
// STRUCTURE
//  hb_pkg: hb_state_t enum (IDLE=0, ARMED=1, RUN=2, STARVED=3, FAULT=4), KICK_CNT_W=16 constant.
//  Sub-module hb_timer:
//    - CNT_W up-counter with clear, enable and terminal-count compare.
//    - Instantiated twice: period timer and host timer.
//  Top holds the FSM, the heartbeat register and the optional kick counter.
// TESTING  (bench parameters KICK_PERIOD=8, HOST_TIMEOUT=40)
//  1. Reset: rstn=0 for 5 cycles, enable=1.
//     -> heartbeat=0, state_o=IDLE. After release: ARMED on the next edge.
//  2. Ping with dsp_ok=1 at cycle t0.
//     -> RUN at t0+1. heartbeat 1-cycle pulses at t0+9, t0+17, t0+25. alive=1.
//  3. No ping for 40 cycles after the last ping.
//     -> STARVED, heartbeat stays 0.
//     Ping at t1 -> RUN; first kick at t1+9.
//  4. dsp_ok=0 only during one terminal cycle.
//     -> that kick missing; the next kick is 8 cycles later.
//  5. wd_triggered=1 for 1 cycle in RUN.
//     -> FAULT, fault=1, no kicks despite pings every 4 cycles.
//     enable=0 for 2 cycles, then 1 -> IDLE, fault=0, then ARMED.
//  6. enable=0 at period count 5, re-enabled 2 cycles later, then ping.
//     -> no stray kick; the period restarts from 0.
//     With HB_KICK_CNT_EN: kick_count unchanged across the enable drop.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared types and constants for the heartbeat kicker.
package hb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      RUN     = 3'd2,
      STARVED = 3'd3,
      FAULT   = 3'd4
   } hb_state_t;

   localparam int unsigned KICK_CNT_W = 16;

endpackage

// File: rtl/heartbeat_kicker_if.sv
// Host/watchdog-facing signal bundle of the heartbeat kicker.
// master: the environment (host regs, DSP status, watchdog); slave: the kicker.
interface heartbeat_kicker_if;
   import hb_pkg::*;

   logic                  enable;
   logic                  host_ping;
   logic                  dsp_ok;
   logic                  wd_triggered;
   logic                  heartbeat;
   logic                  alive;
   logic                  fault;
   logic [2:0]            state_o;
   logic [KICK_CNT_W-1:0] kick_count;

   modport master (
      output enable, host_ping, dsp_ok, wd_triggered,
      input  heartbeat, alive, fault, state_o, kick_count
   );

   modport slave (
      input  enable, host_ping, dsp_ok, wd_triggered,
      output heartbeat, alive, fault, state_o, kick_count
   );

endinterface

// File: rtl/hb_timer.sv
// Wrapping up-counter with synchronous clear, count enable and a
// terminal-count flag (count == LIMIT-1). Used for the kick period and
// for host-starvation detection.
module hb_timer #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned LIMIT = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic term
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 32'd1);
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;

   assign term = (count_r == LAST);

   // Count while enabled, wrap to zero after the terminal value; clear wins.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         if (term) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_r + ONE;
         end
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/heartbeat_kicker.sv
// Heartbeat kicker: issues one-cycle kicks to the watchdog every
// KICK_PERIOD cycles while the host keeps pinging and the DSP path is
// healthy. Stops on host starvation or once the watchdog has fired.
// Optional feature macro: HB_KICK_CNT_EN (saturating kick counter).
module heartbeat_kicker
   import hb_pkg::*;
#(
   parameter int unsigned KICK_PERIOD  = 32'd1250000,
   parameter int unsigned HOST_TIMEOUT = 32'd125000000,
   parameter int unsigned CNT_W        = 32'd32
) (
   input  logic              clk,
   input  logic              rstn,
   heartbeat_kicker_if.slave bus
);

   localparam logic [2:0] S_IDLE    = 3'(IDLE);
   localparam logic [2:0] S_ARMED   = 3'(ARMED);
   localparam logic [2:0] S_RUN     = 3'(RUN);
   localparam logic [2:0] S_STARVED = 3'(STARVED);
   localparam logic [2:0] S_FAULT   = 3'(FAULT);

   logic [2:0] state_r;
   logic [2:0] state_nxt_s;
   logic       heartbeat_r;
   logic       alive_r;
   logic       fault_r;
   logic       hb_nxt_s;
   logic       in_run_s;
   logic       period_clr_s;
   logic       host_clr_s;
   logic       period_term_s;
   logic       host_term_s;

   // Both timers only run in RUN; leaving RUN (or dropping enable)
   // parks them at zero so every RUN entry starts a fresh period.
   assign in_run_s     = (state_r == S_RUN);
   assign period_clr_s = ~in_run_s | ~bus.enable;
   assign host_clr_s   = ~in_run_s | ~bus.enable | bus.host_ping;

   hb_timer #(
      .CNT_W (CNT_W),
      .LIMIT (KICK_PERIOD)
   ) u_period_timer (
      .clk  (clk),
      .rstn (rstn),
      .clr  (period_clr_s),
      .en   (in_run_s),
      .term (period_term_s)
   );

   hb_timer #(
      .CNT_W (CNT_W),
      .LIMIT (HOST_TIMEOUT)
   ) u_host_timer (
      .clk  (clk),
      .rstn (rstn),
      .clr  (host_clr_s),
      .en   (in_run_s),
      .term (host_term_s)
   );

   // Next-state logic: enable drop > watchdog fired > host ping > timeout.
   always_comb begin
      state_nxt_s = state_r;
      if (!bus.enable) begin
         state_nxt_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               state_nxt_s = S_ARMED;
            end
            S_ARMED, S_STARVED: begin
               if (bus.wd_triggered) begin
                  state_nxt_s = S_FAULT;
               end else if (bus.host_ping && bus.dsp_ok) begin
                  state_nxt_s = S_RUN;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            S_RUN: begin
               if (bus.wd_triggered) begin
                  state_nxt_s = S_FAULT;
               end else if (bus.host_ping) begin
                  state_nxt_s = S_RUN;
               end else if (host_term_s) begin
                  state_nxt_s = S_STARVED;
               end else begin
                  state_nxt_s = S_RUN;
               end
            end
            S_FAULT: begin
               state_nxt_s = S_FAULT;
            end
            default: begin
               state_nxt_s = S_IDLE;
            end
         endcase
      end
   end

   // A kick is only emitted if we are in RUN now and stay in RUN, so a
   // heartbeat can never appear outside RUN or on back-to-back cycles.
   always_comb begin
      if (in_run_s && (state_nxt_s == S_RUN) && period_term_s &&
          bus.dsp_ok && !heartbeat_r) begin
         hb_nxt_s = 1'b1;
      end else begin
         hb_nxt_s = 1'b0;
      end
   end

   // State and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r     <= S_IDLE;
         heartbeat_r <= 1'b0;
         alive_r     <= 1'b0;
         fault_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         heartbeat_r <= hb_nxt_s;
         alive_r     <= (state_nxt_s == S_RUN);
         fault_r     <= (state_nxt_s == S_FAULT);
      end
   end

   assign bus.heartbeat = heartbeat_r;
   assign bus.alive     = alive_r;
   assign bus.fault     = fault_r;
   assign bus.state_o   = state_r;

`ifdef HB_KICK_CNT_EN
   localparam logic [KICK_CNT_W-1:0] KICK_MAX = {KICK_CNT_W{1'b1}};
   localparam logic [KICK_CNT_W-1:0] KICK_ONE = {{(KICK_CNT_W-1){1'b0}}, 1'b1};

   logic [KICK_CNT_W-1:0] kick_cnt_r;

   // Saturating count of kicks; only reset clears it, enable does not.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         kick_cnt_r <= {KICK_CNT_W{1'b0}};
      end else if (hb_nxt_s && (kick_cnt_r != KICK_MAX)) begin
         kick_cnt_r <= kick_cnt_r + KICK_ONE;
      end else begin
         kick_cnt_r <= kick_cnt_r;
      end
   end

   assign bus.kick_count = kick_cnt_r;
`else
   assign bus.kick_count = {KICK_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_heartbeat_kicker.sv
// Directed bench for heartbeat_kicker with KICK_PERIOD=8, HOST_TIMEOUT=40.
// A reset/arming/first-kick vector table, then hand-written sequences for
// starvation, revival, skipped kicks, ping-at-timeout, watchdog fault and
// enable drop mid-period.
module tb_heartbeat_kicker;
   import hb_pkg::*;

   localparam int unsigned KP = 8;
   localparam int unsigned HT = 40;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_STARVED = 3'd3;
   localparam logic [2:0] S_FAULT   = 3'd4;

   typedef struct packed {
      logic       rstn;
      logic       en;
      logic       ping;
      logic       dsp;
      logic       wd;
      logic       hb;
      logic [2:0] st;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;

   heartbeat_kicker_if hb_bus ();

   heartbeat_kicker #(
      .KICK_PERIOD  (KP),
      .HOST_TIMEOUT (HT),
      .CNT_W        (32)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (hb_bus)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_pass    = 0;
   int exp_kicks = 0;

   vec_t       vecs [18];
   int         e;
   logic       ehb;
   logic [2:0] est;

   task automatic step(input logic r, input logic en, input logic ping,
                       input logic dsp, input logic wd);
      rstn                = r;
      hb_bus.enable       = en;
      hb_bus.host_ping    = ping;
      hb_bus.dsp_ok       = dsp;
      hb_bus.wd_triggered = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input int idx,
                          input logic exp_hb, input logic [2:0] exp_st);
      logic [5:0] got;
      logic [5:0] exp;
      got = {hb_bus.heartbeat, hb_bus.alive, hb_bus.fault, hb_bus.state_o};
      exp = {exp_hb, (exp_st == S_RUN), (exp_st == S_FAULT), exp_st};
      if (exp_hb) exp_kicks++;
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s[%0d]: {hb,alive,fault,state}=%b required %b",
                  name, idx, got, exp);
      end
   endtask

   task automatic chk_kicks(input string name);
      logic [15:0] exp_k;
`ifdef HB_KICK_CNT_EN
      exp_k = (exp_kicks > 65535) ? 16'hFFFF : 16'(exp_kicks);
`else
      exp_k = 16'h0000;
`endif
      n_checks++;
      if (hb_bus.kick_count === exp_k) begin
         n_pass++;
      end else begin
         $display("FAIL %s: kick_count=%0d required %0d",
                  name, hb_bus.kick_count, exp_k);
      end
   endtask

   // Drop enable for one cycle, then re-enable: back to ARMED.
   task automatic restart(input string name);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_out({name, "_idle"}, 0, 1'b0, S_IDLE);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_out({name, "_armed"}, 0, 1'b0, S_ARMED);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      // rstn, en, ping, dsp, wd -> hb, state (sampled after the edge)
      for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_ARMED};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_ARMED};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_ARMED};
      vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN};
      for (int i = 9; i < 16; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_RUN};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, S_RUN};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_RUN};

      rstn = 1'b0;
      hb_bus.enable = 1'b1;
      hb_bus.host_ping = 1'b0;
      hb_bus.dsp_ok = 1'b1;
      hb_bus.wd_triggered = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].rstn, vecs[i].en, vecs[i].ping, vecs[i].dsp, vecs[i].wd);
         chk_out("table", i, vecs[i].hb, vecs[i].st);
         if (i == 4) chk_kicks("reset_kick_count");
      end
      chk_kicks("table_kicks");

      // Starvation: single ping, kicks every 8, STARVED 40 cycles later.
      // The terminal at the timeout cycle must not kick.
      restart("starve");
      for (int c = 0; c < 45; c++) begin
         step(1'b1, 1'b1, (c == 0), 1'b1, 1'b0);
         e   = c + 1;
         est = (e <= 40) ? S_RUN : S_STARVED;
         ehb = (e >= 9) && (e <= 40) && (((e - 1) % 8) == 0);
         chk_out("starve", e, ehb, est);
      end

      // Revival from STARVED: first kick 9 cycles after the ping.
      for (int c = 0; c < 11; c++) begin
         step(1'b1, 1'b1, (c == 0), 1'b1, 1'b0);
         e = c + 1;
         chk_out("revive", e, (e == 9), S_RUN);
      end
      chk_kicks("revive_kicks");

      // dsp_ok low only in the first terminal cycle: that kick is skipped.
      restart("dsp");
      for (int c = 0; c < 19; c++) begin
         step(1'b1, 1'b1, (c == 0), (c != 8), 1'b0);
         e = c + 1;
         chk_out("dsp_skip", e, (e == 17), S_RUN);
      end

      // Ping in the timeout cycle keeps RUN; period undisturbed.
      restart("pingtmo");
      for (int c = 0; c < 49; c++) begin
         step(1'b1, 1'b1, (c == 0) || (c == 40), 1'b1, 1'b0);
         e   = c + 1;
         ehb = (e >= 9) && (((e - 1) % 8) == 0);
         chk_out("ping_at_timeout", e, ehb, S_RUN);
      end
      chk_kicks("pingtmo_kicks");

      // Watchdog fires in a terminal cycle: no kick, FAULT, pings ignored.
      restart("wd");
      for (int c = 0; c < 31; c++) begin
         step(1'b1, 1'b1, ((c % 4) == 0), 1'b1, (c == 8));
         e   = c + 1;
         est = (e <= 8) ? S_RUN : S_FAULT;
         chk_out("wd_fault", e, 1'b0, est);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_out("fault_exit", 0, 1'b0, S_IDLE);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_out("fault_exit", 1, 1'b0, S_IDLE);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_out("fault_exit", 2, 1'b0, S_ARMED);

      // Enable drop at period count 5 of the second period, re-enable two
      // cycles later, ping: no stray kick, period restarts from zero.
      restart("endrop");
      for (int c = 0; c < 28; c++) begin
         step(1'b1, !((c == 14) || (c == 15)), (c == 0) || (c == 17), 1'b1, 1'b0);
         e = c + 1;
         if (e <= 14)                   est = S_RUN;
         else if (e == 15 || e == 16)   est = S_IDLE;
         else if (e == 17)              est = S_ARMED;
         else                           est = S_RUN;
         chk_out("enable_drop", e, (e == 9) || (e == 26), est);
         if (c == 16) chk_kicks("kicks_across_enable_drop");
      end
      chk_kicks("final_kicks");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
